// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared types and constants for the boot loader
package imem_boot_loader_pkg;
    localparam int ADDR_W    = 12;
    localparam int INSTR_W   = 19;
    localparam int MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_PAD  = 2'd3;
endpackage

// File: rtl/imem_boot_loader_boot_word_assembler.sv
// boot_word_assembler: byte lanes, pad-bit check and running XOR of the stream
module boot_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               acc_i,
    input  state_e             state_i,
    input  logic [7:0]         byte_i,
    output logic [INSTR_W-1:0] wdata_o,
    output logic               pad_bad_o,
    output logic [7:0]         csum_o
);
    logic [7:0]         b0_q, b1_q, csum_q;
    logic [INSTR_W-1:0] wdata_q;

    assign pad_bad_o = |byte_i[7:3];
    assign wdata_o   = wdata_q;
    assign csum_o    = csum_q;

    // capture lanes, latch a word only when its top byte has clean pad bits, fold bytes into the XOR
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b0_q    <= '0;
            b1_q    <= '0;
            wdata_q <= '0;
            csum_q  <= '0;
        end else begin
            if (acc_i && state_i == S_B0) b0_q <= byte_i;
            if (acc_i && state_i == S_B1) b1_q <= byte_i;
            if (acc_i && state_i == S_B2 && !pad_bad_o) wdata_q <= {byte_i[2:0], b1_q, b0_q};
            if (clr_i) csum_q <= '0;
            else if (acc_i) csum_q <= csum_q ^ byte_i;
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a checksummed byte-stream image into instruction memory, halting the core until done
module imem_boot_loader
    import imem_boot_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_data_i,
    output logic               byte_ready_o,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic [INSTR_W-1:0] imem_wdata_o,
    output logic               core_halt_o,
    output logic               done_o,
    output logic               error_o,
    output logic [1:0]         err_code_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d;
    logic [7:0]        lo_q, lo_d, csum;
    logic [1:0]        err_q, err_d;
    logic [15:0]       n;
    logic              acc, clr, pad_bad;

    assign byte_ready_o = state_q inside {S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_CHK};
    assign acc          = byte_valid_i && byte_ready_o;
    assign clr          = start_i && (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign n            = {byte_data_i, lo_q};
    assign imem_we_o    = state_q == S_WRITE;
    assign imem_addr_o  = addr_q;
    assign core_halt_o  = state_q != S_DONE;
    assign done_o       = state_q == S_DONE;
    assign error_o      = state_q == S_ERR;
    assign err_code_o   = err_q;

    boot_word_assembler u_asm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr),
        .acc_i     (acc && state_q != S_CHK),
        .state_i   (state_q),
        .byte_i    (byte_data_i),
        .wdata_o   (imem_wdata_o),
        .pad_bad_o (pad_bad),
        .csum_o    (csum)
    );

    // state, write address (doubles as word counter), length and error registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            lo_q    <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    // next-state: parse length, three bytes per word, one write cycle, then the checksum byte
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        lo_d    = lo_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_LEN_LO;
            S_LEN_LO: if (acc) begin
                lo_d    = byte_data_i;
                state_d = S_LEN_HI;
            end
            S_LEN_HI: if (acc) begin
                if (n != 16'd0 && n <= 16'(MAX_WORDS)) begin
                    last_d  = ADDR_W'(n - 16'd1);
                    state_d = S_B0;
                end else begin
                    err_d   = ERR_LEN;
                    state_d = S_ERR;
                end
            end
            S_B0:     if (acc) state_d = S_B1;
            S_B1:     if (acc) state_d = S_B2;
            S_B2:     if (acc) begin
                err_d   = pad_bad ? ERR_PAD : err_q;
                state_d = pad_bad ? S_ERR : S_WRITE;
            end
            S_WRITE:  begin
                state_d = addr_q == last_q ? S_CHK : S_B0;
                addr_d  = addr_q == last_q ? addr_q : addr_q + 1'b1;
            end
            S_CHK:    if (acc) begin
                err_d   = byte_data_i == csum ? ERR_NONE : ERR_CSUM;
                state_d = byte_data_i == csum ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: if (start_i) begin
                err_d   = ERR_NONE;
                addr_d  = '0;
                state_d = S_LEN_LO;
            end
            default:  state_d = S_IDLE;
        endcase
    end
endmodule
